// File: rtl/dmem_bank_backend_pkg.sv
// Shared types and helpers for the banked data-memory backend.
package dmem_bank_backend_pkg;

  // Per-channel request lifecycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } mem_chan_state_t;

  // Bank index is the low address bits; num_banks is a power of two.
  function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned num_banks);
    return (num_banks <= 1) ? 0 : (addr & (num_banks - 1));
  endfunction

endpackage

// File: rtl/dmem_bank_backend_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the stored pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_req,
  input  logic         i_ptr_update,
  output logic [N-1:0] o_grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W:0]   w_sum;
  logic             w_found;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    o_grant  = '0;
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
      if (w_sum >= (PTR_W + 1)'(N)) w_sum = w_sum - (PTR_W + 1)'(N);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_winner       = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; untouched when nobody bids.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_ptr_update && w_found) begin
      r_ptr <= (w_winner == PTR_W'(N - 1)) ? '0 : w_winner + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_bank_backend.sv
// Multi-channel banked data memory with per-bank round-robin arbitration
// and a fixed grant-to-ready latency per channel.
module dmem_bank_backend
  import dmem_bank_backend_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_BANKS    = 2,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] i_mem_read_valid,
  input  logic [ADDR_BITS-1:0]    i_mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] o_mem_read_ready,
  output logic [DATA_BITS-1:0]    o_mem_read_data    [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] i_mem_write_valid,
  input  logic [ADDR_BITS-1:0]    i_mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    i_mem_write_data    [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] o_mem_write_ready,
  input  logic                    i_init_we,
  input  logic [ADDR_BITS-1:0]    i_init_addr,
  input  logic [DATA_BITS-1:0]    i_init_data
);

  localparam int DEPTH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_CNT = (LATENCY > 1) ? LATENCY - 2 : 0;

  logic [DATA_BITS-1:0]    r_mem [DEPTH];

  logic [NUM_CHANNELS-1:0] w_idle;
  logic [NUM_CHANNELS-1:0] w_req;
  logic [NUM_CHANNELS-1:0] w_req_is_read;
  logic [NUM_CHANNELS-1:0] w_in_range;
  logic [NUM_CHANNELS-1:0] w_gnt;
  logic [ADDR_BITS-1:0]    w_addr    [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    w_rd_word [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_bank_req [NUM_BANKS];
  logic [NUM_CHANNELS-1:0] w_bank_gnt [NUM_BANKS];

  // Decode each idle channel's request: read wins over write; no bids during reset.
  always_comb begin
    w_req         = '0;
    w_req_is_read = '0;
    w_in_range    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_req_is_read[c] = i_mem_read_valid[c];
      w_addr[c]        = i_mem_read_valid[c] ? i_mem_read_address[c] : i_mem_write_address[c];
      w_in_range[c]    = (32'(w_addr[c]) < DEPTH);
      w_req[c]         = !reset && w_idle[c] && (i_mem_read_valid[c] || i_mem_write_valid[c]);
      w_rd_word[c]     = w_in_range[c] ? r_mem[w_addr[c][DEPTH_W-1:0]] : '0;
    end
  end

  // Route each bid to the bank its address maps to.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_req[b] = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        w_bank_req[b][c] = w_req[c] && (bank_of(32'(w_addr[c]), NUM_BANKS) == 32'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
      .clk          (clk),
      .reset        (reset),
      .i_req        (w_bank_req[b]),
      .i_ptr_update (|w_bank_req[b]),
      .o_grant      (w_bank_gnt[b])
    );
  end

  // A channel bids in exactly one bank, so OR-ing the bank grants is unambiguous.
  always_comb begin
    w_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) w_gnt = w_gnt | w_bank_gnt[b];
  end

  // Array update: granted channel writes first, backdoor preload last so it wins.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_gnt[c] && !w_req_is_read[c] && w_in_range[c]) begin
        r_mem[w_addr[c][DEPTH_W-1:0]] <= i_mem_write_data[c];
      end
    end
    if (i_init_we && (32'(i_init_addr) < DEPTH)) begin
      r_mem[i_init_addr[DEPTH_W-1:0]] <= i_init_data;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_chan_state_t      r_state;
    mem_chan_state_t      w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_read;
    logic [DATA_BITS-1:0] r_rd_pipe;
    logic [DATA_BITS-1:0] r_rd_data;
    logic                 w_rd_ready;
    logic                 w_wr_ready;

    // Channel state register.
    always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
    end

    // Next-state logic; DRAIN holds until both valids are seen low.
    always_comb begin
      w_state_next = r_state;
      case (r_state)
        IDLE:    if (w_gnt[c]) w_state_next = (LATENCY == 1) ? RESP : BUSY;
        BUSY:    if (r_cnt == '0) w_state_next = RESP;
        RESP:    w_state_next = DRAIN;
        DRAIN:   if (!i_mem_read_valid[c] && !i_mem_write_valid[c]) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end

    // Ready pulses are a pure decode of RESP and the captured direction.
    always_comb begin
      w_rd_ready = (r_state == RESP) && r_is_read;
      w_wr_ready = (r_state == RESP) && !r_is_read;
    end

    // Latency counter and request direction, loaded at grant.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt     <= '0;
        r_is_read <= 1'b0;
      end else if (w_gnt[c]) begin
        r_is_read <= w_req_is_read[c];
        r_cnt     <= CNT_W'(LAT_CNT);
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    // Read word captured at the grant edge.
    always_ff @(posedge clk) begin
      if (w_gnt[c] && w_req_is_read[c]) r_rd_pipe <= w_rd_word[c];
    end

    // Visible read data changes only as a read enters RESP, then holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd_data <= '0;
      end else if (LATENCY == 1) begin
        if (w_gnt[c] && w_req_is_read[c]) r_rd_data <= w_rd_word[c];
      end else if ((r_state == BUSY) && (r_cnt == '0) && r_is_read) begin
        r_rd_data <= r_rd_pipe;
      end
    end

    assign w_idle[c]            = (r_state == IDLE);
    assign o_mem_read_ready[c]  = w_rd_ready;
    assign o_mem_write_ready[c] = w_wr_ready;
    assign o_mem_read_data[c]   = r_rd_data;
  end

endmodule
